l2_victim_cache: RTL and testbench
==================================

// Module: l2_victim_cache
// PURPOSE
//  Responder on the L2 pmem-side interface, between the L2 controller and physical memory.
//  Absorbs clean evictions (l2_evict pulse) and dirty write-backs (l2_write) into a small
//  fully-associative line buffer. Serves L2 line fetches (l2_read) from that buffer on a hit
//  and forwards misses to pmem. Dirty lines it displaces are drained to pmem.
// PARAMETERS
//  NUM_ENTRIES  4    victim lines held, fully associative; IDX_W = $clog2(NUM_ENTRIES)
//  ADDR_W       16   word address width; tag = addr[ADDR_W-1:4]
//  LINE_W       128  cache line width (16 bytes)
// PORTS
//  clk           in   1       clock
//  rst_n         in   1       synchronous reset, active low
//  l2_read       in   1       line fetch request; held until l2_resp
//  l2_write      in   1       dirty write-back request; held until l2_resp
//  l2_evict      in   1       1-cycle pulse: clean valid line evicted; no response
//  l2_address    in   ADDR_W  line address of request/evict; bits [3:0] ignored
//  l2_wdata      in   LINE_W  line data for write/evict
//  l2_rdata      out  LINE_W  fetched line, registered; valid when l2_resp=1
//  l2_resp       out  1       1-cycle completion pulse for read/write
//  pmem_read     out  1       read request to memory, held until pmem_resp
//  pmem_write    out  1       write request to memory, held until pmem_resp
//  pmem_address  out  ADDR_W  registered; [3:0] forced to 0
//  pmem_wdata    out  LINE_W  registered drain data
//  pmem_rdata    in   LINE_W  memory read data, valid with pmem_resp
//  pmem_resp     in   1       memory completion, 1 cycle
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE; all valid/dirty=0; fifo_ptr=0; wbuf_valid=0; every
//   output 0. Reset mid-transfer abandons it, including undrained wbuf data (accepted loss).
//   pmem_read/pmem_write go low after that edge.
//  Entry: valid, dirty, tag, data. Lookup: hit = valid & tag match; at most one hit.
//  Slot choice on insert: tag-hit entry, else lowest invalid index, else fifo_ptr.
//   fifo_ptr increments (wrapping mod NUM_ENTRIES) only when a valid entry is displaced.
//   If the displaced entry is dirty, copy it to wbuf (wbuf_valid=1) in the same cycle.
//  Priority if several requests are asserted in IDLE: evict > write > read (a protocol
//   error; L2 never does this).
//  States: IDLE, HIT_RESP, MEM_READ, READ_RESP, WRITE_RESP, DRAIN.
//  IDLE, evict:
//   - Insert clean (dirty=0).
//   - On a tag hit, data is overwritten and dirty is kept.
//   - Next state: DRAIN if wbuf_valid, else IDLE.
//  IDLE, write:
//   - Insert with dirty=1 (overwrites on tag hit).
//   - Next state: WRITE_RESP.
//  WRITE_RESP: l2_resp=1. Next state: DRAIN if wbuf_valid, else IDLE.
//  IDLE, read hit:
//   - l2_rdata<=entry data.
//   - Clean entry: invalidated.
//   - Dirty entry: stays valid and dirty, because L2 installs fetched lines clean.
//   - Next state: HIT_RESP, with l2_resp=1 one cycle after acceptance. No pmem access.
//  IDLE, read miss:
//   - pmem_address<={addr[15:4],4'b0}.
//   - Next state: MEM_READ, with pmem_read=1 until pmem_resp.
//   - On pmem_resp: l2_rdata<=pmem_rdata, next state READ_RESP.
//   - READ_RESP: l2_resp=1. No allocation on a miss.
//  DRAIN:
//   - pmem_write=1 with wbuf address/data until pmem_resp.
//   - Then wbuf_valid=0, next state IDLE.
//   - New requests wait (no l2_resp) until drain completes.
//  l2_resp is exactly 1 cycle.
//  No request is accepted in the cycle l2_resp=1, because acceptance happens only in IDLE.
//  l2_rdata holds its value until the next read completes.
// TESTING
//  T1 reset; read 0x1230 -> pmem_read=1, pmem_address=0x1230; pmem_resp with D0 -> next
//     cycle l2_resp=1, l2_rdata=D0; no entry allocated (repeat read misses again).
//  T2 evict 0x4560/A; read 0x4568 -> l2_resp 1 cycle after accept, rdata=A, pmem_read
//     never 1; read 0x4560 again -> miss to pmem (entry invalidated).
//  T3 write 0x7770/B -> l2_resp next cycle; read 0x7770 -> hit, B, entry kept dirty;
//     evict 0x1000,0x2000,0x3000 fill slots 1-3; evict 0x5000 displaces slot0 ->
//     DRAIN with pmem_write=1, pmem_address=0x7770, pmem_wdata=B until pmem_resp.
//  T4 read 0x9990 issued during DRAIN -> no pmem_read and no l2_resp until drain
//     pmem_resp; then normal miss flow.
//  T5 evict 0x4560/A, then write 0x4560/C -> same slot, dirty=1, fifo_ptr unchanged,
//     no drain; read -> C.
//  T6 rst_n=0 while in MEM_READ -> pmem_read=0 after edge; a read of a previously
//     evicted line then misses.

Source files
------------

// File: rtl/l2_victim_cache_if.sv
// L2 <-> victim cache <-> pmem bus bundle.
// slave  : the victim cache (responds to L2, requests to pmem)
// master : the environment (L2 controller and physical memory)
interface l2_victim_cache_if #(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128
);
   logic              l2_read;
   logic              l2_write;
   logic              l2_evict;
   logic [ADDR_W-1:0] l2_address;
   logic [LINE_W-1:0] l2_wdata;
   logic [LINE_W-1:0] l2_rdata;
   logic              l2_resp;
   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   logic [LINE_W-1:0] pmem_wdata;
   logic [LINE_W-1:0] pmem_rdata;
   logic              pmem_resp;

   modport slave (
      input  l2_read, l2_write, l2_evict, l2_address, l2_wdata,
      output l2_rdata, l2_resp,
      output pmem_read, pmem_write, pmem_address, pmem_wdata,
      input  pmem_rdata, pmem_resp
   );

   modport master (
      output l2_read, l2_write, l2_evict, l2_address, l2_wdata,
      input  l2_rdata, l2_resp,
      input  pmem_read, pmem_write, pmem_address, pmem_wdata,
      output pmem_rdata, pmem_resp
   );
endinterface

// File: rtl/l2_victim_cache.sv
// Victim line buffer between the L2 controller and physical memory.
// Absorbs clean evictions and dirty write-backs, serves L2 fetches on a hit,
// forwards misses to pmem and drains displaced dirty lines.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | accepting requests (evict > write > read)
// HIT_RESP   | read hit, l2_rdata loaded, l2_resp pulse
// MEM_READ   | read miss, pmem_read held until pmem_resp
// READ_RESP  | miss data loaded into l2_rdata, l2_resp pulse
// WRITE_RESP | write-back absorbed, l2_resp pulse
// DRAIN      | displaced dirty line in wbuf, pmem_write held until pmem_resp
module l2_victim_cache #(
   parameter int NUM_ENTRIES = 4,
   parameter int ADDR_W      = 16,
   parameter int LINE_W      = 128
) (
   input  logic               clk,
   input  logic               rst_n,
   l2_victim_cache_if.slave   bus
);

   localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
   localparam int TAG_W = ADDR_W - 4;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

   typedef enum logic [2:0] {
      IDLE,
      HIT_RESP,
      MEM_READ,
      READ_RESP,
      WRITE_RESP,
      DRAIN
   } state_t;

   state_t                 state_q, state_d;
   logic [NUM_ENTRIES-1:0] valid_q, valid_d;
   logic [NUM_ENTRIES-1:0] dirty_q, dirty_d;
   logic [TAG_W-1:0]       tag_q  [NUM_ENTRIES];
   logic [TAG_W-1:0]       tag_d  [NUM_ENTRIES];
   logic [LINE_W-1:0]      data_q [NUM_ENTRIES];
   logic [LINE_W-1:0]      data_d [NUM_ENTRIES];
   logic [IDX_W-1:0]       fifo_ptr_q, fifo_ptr_d;
   logic                   wbuf_valid_q, wbuf_valid_d;
   logic [TAG_W-1:0]       wbuf_tag_q, wbuf_tag_d;
   logic [LINE_W-1:0]      wbuf_data_q, wbuf_data_d;
   logic [LINE_W-1:0]      l2_rdata_q, l2_rdata_d;
   logic [TAG_W-1:0]       pmem_tag_q, pmem_tag_d;
   logic [LINE_W-1:0]      pmem_wdata_q, pmem_wdata_d;

   logic [TAG_W-1:0]       req_tag;
   logic                   hit;
   logic [IDX_W-1:0]       hit_idx;
   logic                   free_found;
   logic [IDX_W-1:0]       free_idx;
   logic [IDX_W-1:0]       slot_idx;
   logic                   displace;
   logic                   unused_addr_bits;

   assign req_tag          = bus.l2_address[ADDR_W-1:4];
   assign unused_addr_bits = ^bus.l2_address[3:0];

   // Associative lookup: matching valid entry and lowest free slot
   always_comb begin
      hit        = 1'b0;
      hit_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (valid_q[i] && (tag_q[i] == req_tag)) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
         if (!valid_q[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   // Insert slot: tag hit, else lowest free, else round-robin victim
   always_comb begin
      displace = !hit && !free_found;
      if (hit) begin
         slot_idx = hit_idx;
      end else if (free_found) begin
         slot_idx = free_idx;
      end else begin
         slot_idx = fifo_ptr_q;
      end
   end

   // Next-state, buffer update and output register inputs
   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      dirty_d      = dirty_q;
      tag_d        = tag_q;
      data_d       = data_q;
      fifo_ptr_d   = fifo_ptr_q;
      wbuf_valid_d = wbuf_valid_q;
      wbuf_tag_d   = wbuf_tag_q;
      wbuf_data_d  = wbuf_data_q;
      l2_rdata_d   = l2_rdata_q;
      pmem_tag_d   = pmem_tag_q;
      pmem_wdata_d = pmem_wdata_q;

      unique case (state_q)
         IDLE: begin
            if (bus.l2_evict || bus.l2_write) begin
               if (displace) begin
                  fifo_ptr_d = (fifo_ptr_q == LAST_IDX) ? '0 : fifo_ptr_q + IDX_W'(1);
                  if (dirty_q[fifo_ptr_q]) begin
                     wbuf_valid_d = 1'b1;
                     wbuf_tag_d   = tag_q[fifo_ptr_q];
                     wbuf_data_d  = data_q[fifo_ptr_q];
                  end
               end
               valid_d[slot_idx] = 1'b1;
               tag_d[slot_idx]   = req_tag;
               data_d[slot_idx]  = bus.l2_wdata;
               if (bus.l2_evict) begin
                  // a clean evict over a dirty copy must not lose the dirty mark
                  dirty_d[slot_idx] = hit & dirty_q[slot_idx];
                  state_d           = wbuf_valid_d ? DRAIN : IDLE;
               end else begin
                  dirty_d[slot_idx] = 1'b1;
                  state_d           = WRITE_RESP;
               end
            end else if (bus.l2_read) begin
               if (hit) begin
                  l2_rdata_d = data_q[hit_idx];
                  // L2 re-installs the line clean, so a dirty copy must stay here
                  if (!dirty_q[hit_idx]) begin
                     valid_d[hit_idx] = 1'b0;
                  end
                  state_d = HIT_RESP;
               end else begin
                  pmem_tag_d = req_tag;
                  state_d    = MEM_READ;
               end
            end
         end
         HIT_RESP:   state_d = IDLE;
         READ_RESP:  state_d = IDLE;
         WRITE_RESP: state_d = wbuf_valid_q ? DRAIN : IDLE;
         MEM_READ: begin
            if (bus.pmem_resp) begin
               l2_rdata_d = bus.pmem_rdata;
               state_d    = READ_RESP;
            end
         end
         DRAIN: begin
            if (bus.pmem_resp) begin
               wbuf_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // pmem address/data are loaded once, on the way into DRAIN
      if ((state_d == DRAIN) && (state_q != DRAIN)) begin
         pmem_tag_d   = wbuf_tag_d;
         pmem_wdata_d = wbuf_data_d;
      end
   end

   // Control state and output registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         valid_q      <= '0;
         dirty_q      <= '0;
         fifo_ptr_q   <= '0;
         wbuf_valid_q <= 1'b0;
         l2_rdata_q   <= '0;
         pmem_tag_q   <= '0;
         pmem_wdata_q <= '0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         dirty_q      <= dirty_d;
         fifo_ptr_q   <= fifo_ptr_d;
         wbuf_valid_q <= wbuf_valid_d;
         l2_rdata_q   <= l2_rdata_d;
         pmem_tag_q   <= pmem_tag_d;
         pmem_wdata_q <= pmem_wdata_d;
      end
   end

   // Line storage; contents are meaningless while the valid bit is clear
   always_ff @(posedge clk) begin
      tag_q       <= tag_d;
      data_q      <= data_d;
      wbuf_tag_q  <= wbuf_tag_d;
      wbuf_data_q <= wbuf_data_d;
   end

   assign bus.l2_resp      = (state_q == HIT_RESP) || (state_q == READ_RESP) ||
                             (state_q == WRITE_RESP);
   assign bus.l2_rdata     = l2_rdata_q;
   assign bus.pmem_read    = (state_q == MEM_READ);
   assign bus.pmem_write   = (state_q == DRAIN);
   assign bus.pmem_address = {pmem_tag_q, 4'b0000};
   assign bus.pmem_wdata   = pmem_wdata_q;

endmodule

// File: tb/tb_l2_victim_cache.sv
// Transaction-level bench for l2_victim_cache: directed scenarios, then
// random evict/write/read traffic against a line-buffer reference model.
module tb_l2_victim_cache;

   logic clk;
   logic rst_n;

   l2_victim_cache_if #(.ADDR_W(16), .LINE_W(128)) bus ();

   l2_victim_cache #(.NUM_ENTRIES(4), .ADDR_W(16), .LINE_W(128)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // reference model of the buffer
   bit           m_valid [4];
   bit           m_dirty [4];
   logic [11:0]  m_tag   [4];
   logic [127:0] m_data  [4];
   int           m_fifo;
   logic [11:0]  exp_dtag_q  [$];
   logic [127:0] exp_ddata_q [$];
   logic [127:0] last_rdata;

   // memory responder state
   logic [127:0] mem [logic [11:0]];
   logic [15:0]  wr_addr_log [$];
   logic [127:0] wr_data_log [$];
   logic [15:0]  rd_log [$];
   bit           mem_hold = 1'b0;
   int           lat = -1;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] mem_val(input logic [11:0] t);
      if (!mem.exists(t)) mem[t] = {$urandom, $urandom, $urandom, $urandom};
      return mem[t];
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < 4; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      m_fifo = 0;
      exp_dtag_q.delete();
      exp_ddata_q.delete();
      wr_addr_log.delete();
      wr_data_log.delete();
      rd_log.delete();
      last_rdata = '0;
   endfunction

   function automatic void m_insert(input logic [11:0] t, input logic [127:0] d, input bit is_write);
      int s = -1;
      bit was_hit;
      for (int i = 0; i < 4; i++) if (m_valid[i] && m_tag[i] == t) s = i;
      was_hit = (s >= 0);
      if (s < 0) for (int i = 0; i < 4; i++) if (s < 0 && !m_valid[i]) s = i;
      if (s < 0) begin
         s = m_fifo;
         if (m_dirty[s]) begin
            exp_dtag_q.push_back(m_tag[s]);
            exp_ddata_q.push_back(m_data[s]);
         end
         m_fifo = (m_fifo + 1) % 4;
      end
      m_valid[s] = 1'b1;
      m_tag[s]   = t;
      m_data[s]  = d;
      m_dirty[s] = is_write ? 1'b1 : (was_hit ? m_dirty[s] : 1'b0);
   endfunction

   // pmem model: random 0..3 cycle latency, 1-cycle response
   always @(negedge clk) begin
      bus.pmem_resp = 1'b0;
      if (rst_n && !mem_hold && (bus.pmem_read || bus.pmem_write)) begin
         if (lat < 0) lat = $urandom_range(0, 3);
         if (lat == 0) begin
            bus.pmem_resp = 1'b1;
            if (bus.pmem_read) begin
               bus.pmem_rdata = mem_val(bus.pmem_address[15:4]);
               rd_log.push_back(bus.pmem_address);
            end else begin
               wr_addr_log.push_back(bus.pmem_address);
               wr_data_log.push_back(bus.pmem_wdata);
            end
            lat = -1;
         end else begin
            lat--;
         end
      end else begin
         lat = -1;
      end
   end

   task automatic check_drains();
      while (wr_addr_log.size() > 0) begin
         logic [15:0]  a = wr_addr_log.pop_front();
         logic [127:0] d = wr_data_log.pop_front();
         if (exp_dtag_q.size() == 0) begin
            chk("unexpected_drain_addr", a, 16'hxxxx);
         end else begin
            logic [11:0]  et = exp_dtag_q.pop_front();
            logic [127:0] ed = exp_ddata_q.pop_front();
            chk("drain_addr", a, {et, 4'h0});
            chk("drain_data", d, ed);
            mem[et] = ed;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_drains();
      if (bus.pmem_read && bus.pmem_write) chk("pmem_rd_wr_exclusive", 1, 0);
   endtask

   task automatic wait_drains();
      int cyc = 0;
      if (exp_dtag_q.size() == 0) return;
      while (exp_dtag_q.size() > 0 && cyc < 60) begin
         step();
         cyc++;
      end
      if (exp_dtag_q.size() > 0) begin
         chk("drain_timeout", exp_dtag_q.size(), 0);
         exp_dtag_q.delete();
         exp_ddata_q.delete();
      end
      step();
   endtask

   task automatic do_evict(input logic [15:0] addr, input logic [127:0] d);
      wait_drains();
      bus.l2_address = addr;
      bus.l2_wdata   = d;
      bus.l2_evict   = 1'b1;
      m_insert(addr[15:4], d, 1'b0);
      step();
      bus.l2_evict = 1'b0;
      chk("evict_no_resp", bus.l2_resp, 0);
      chk("evict_rdata_hold", bus.l2_rdata, last_rdata);
   endtask

   task automatic do_write(input logic [15:0] addr, input logic [127:0] d);
      int cyc = 0;
      int pr = 0;
      bit had_drain = (exp_dtag_q.size() > 0);
      bus.l2_address = addr;
      bus.l2_wdata   = d;
      bus.l2_write   = 1'b1;
      m_insert(addr[15:4], d, 1'b1);
      do begin
         step();
         cyc++;
         if (bus.pmem_read) pr++;
      end while (!bus.l2_resp && cyc < 60);
      bus.l2_write = 1'b0;
      chk("write_resp", bus.l2_resp, 1);
      if (!had_drain) chk("write_latency", cyc, 1);
      chk("write_no_pmem_read", pr, 0);
      chk("write_rdata_hold", bus.l2_rdata, last_rdata);
      step();
      chk("write_resp_one_cycle", bus.l2_resp, 0);
   endtask

   task automatic do_read(input logic [15:0] addr);
      logic [11:0]  t = addr[15:4];
      int           s = -1;
      int           cyc = 0;
      int           pr = 0;
      int           rd_n = rd_log.size();
      bit           had_drain = (exp_dtag_q.size() > 0);
      logic [127:0] exp;
      for (int i = 0; i < 4; i++) if (m_valid[i] && m_tag[i] == t) s = i;
      bus.l2_address = addr;
      bus.l2_read    = 1'b1;
      do begin
         step();
         cyc++;
         if (bus.pmem_read) pr++;
         if ((bus.pmem_read || bus.l2_resp) && exp_dtag_q.size() > 0)
            chk("read_waits_for_drain", 1, 0);
      end while (!bus.l2_resp && cyc < 60);
      bus.l2_read = 1'b0;
      chk("read_resp", bus.l2_resp, 1);
      if (s >= 0) begin
         exp = m_data[s];
         if (!m_dirty[s]) m_valid[s] = 1'b0;
         chk("hit_no_pmem_read", pr, 0);
         if (!had_drain) chk("hit_latency", cyc, 1);
      end else begin
         chk("miss_pmem_requests", rd_log.size() - rd_n, 1);
         if (rd_log.size() > rd_n) chk("miss_pmem_addr", rd_log[rd_log.size() - 1], {t, 4'h0});
         exp = mem_val(t);
      end
      chk("read_data", bus.l2_rdata, exp);
      last_rdata = exp;
      step();
      chk("read_resp_one_cycle", bus.l2_resp, 0);
      chk("read_rdata_hold", bus.l2_rdata, last_rdata);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.l2_read  = 1'b0;
      bus.l2_write = 1'b0;
      bus.l2_evict = 1'b0;
      step();
      step();
      chk("rst_l2_resp", bus.l2_resp, 0);
      chk("rst_l2_rdata", bus.l2_rdata, 0);
      chk("rst_pmem_read", bus.pmem_read, 0);
      chk("rst_pmem_write", bus.pmem_write, 0);
      chk("rst_pmem_address", bus.pmem_address, 0);
      chk("rst_pmem_wdata", bus.pmem_wdata, 0);
      rst_n = 1'b1;
      m_reset();
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0]  pool [8];
      logic [127:0] da, db, dc;
      int           cyc;
      rst_n          = 1'b0;
      bus.l2_read    = 1'b0;
      bus.l2_write   = 1'b0;
      bus.l2_evict   = 1'b0;
      bus.l2_address = '0;
      bus.l2_wdata   = '0;
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = '0;
      m_reset();
      da = {4{32'hAAAA_0001}};
      db = {4{32'hBBBB_0002}};
      dc = {4{32'hCCCC_0003}};

      // T1: miss, no allocation
      do_reset();
      do_read(16'h1230);
      do_read(16'h1230);
      // T2: clean hit invalidates
      do_evict(16'h4560, da);
      do_read(16'h4568);
      do_read(16'h4560);
      // T3: dirty hit kept, displacement drains it
      do_write(16'h7770, db);
      do_read(16'h7770);
      do_evict(16'h1000, {4{32'h1000_1000}});
      do_evict(16'h2000, {4{32'h2000_2000}});
      do_evict(16'h3000, {4{32'h3000_3000}});
      do_evict(16'h5000, {4{32'h5000_5000}});
      chk("t3_drain_pending", exp_dtag_q.size(), 1);
      // T4: read issued while draining
      do_read(16'h9990);
      // T5: write over an evicted line hits in place
      do_evict(16'h4560, da);
      do_write(16'h4560, dc);
      do_read(16'h4560);
      wait_drains();

      // random traffic over a small tag pool to force hits and displacement
      for (int i = 0; i < 8; i++) pool[i] = 12'(16'h0A0 + i * 3);
      for (int n = 0; n < 400; n++) begin
         logic [15:0]  a = {pool[$urandom_range(0, 7)], 4'($urandom_range(0, 15))};
         logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
         int           k = $urandom_range(0, 99);
         if (k < 35)      do_evict(a, d);
         else if (k < 65) do_write(a, d);
         else             do_read(a);
      end
      wait_drains();

      // T6: reset while waiting on memory
      do_evict(16'hABC0, da);
      wait_drains();
      mem_hold = 1'b1;
      bus.l2_address = 16'hDEF0;
      bus.l2_read    = 1'b1;
      cyc = 0;
      do begin
         step();
         cyc++;
      end while (!bus.pmem_read && cyc < 20);
      chk("t6_in_mem_read", bus.pmem_read, 1);
      rst_n = 1'b0;
      bus.l2_read = 1'b0;
      step();
      chk("t6_pmem_read_dropped", bus.pmem_read, 0);
      chk("t6_no_resp", bus.l2_resp, 0);
      rst_n = 1'b1;
      mem_hold = 1'b0;
      m_reset();
      step();
      do_read(16'hABC0);
      wait_drains();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
